cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 8-bit core. Fetches 16-bit instructions as two bytes over the shared 8-bit memory bus and presents the opcode to the instruction decode ROM. It latches the ROM's ALU and control flags, then steps the datapath through execute, memory and writeback with one-cycle strobes. It owns the memory request handshake for both instruction fetch and load/store, and traps on undefined opcodes.

## Interface
- No parameters; widths are fixed by the ISA (4-bit opcode, 16-bit instruction, 8-bit bus).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start/continue execution; sampled in IDLE and at instruction end.
- mem_ack  in  1  bus handshake completion; valid only while mem_req=1.
- mem_rdata  in  8  read byte; valid in the cycle where mem_ack=1.
- cond_true  in  1  datapath branch condition, sampled in EXEC.
- alu_flags  in  8  from decode ROM: ci nb ic na xo no rot -.
- ctrl_flags  in  8  from decode ROM, bit7..0: cond_pc, imm, pc_imm, pc_reg, link, mw, mr, ld.
- opcode  out  4  ir[15:12], to decode ROM.
- ir  out  16  instruction register.
- alu_ctrl  out  8  latched alu_flags, held from EXEC until next DECODE.
- imm_sel  out  1  latched ctrl bit6.
- mem_req  out  1  bus request.
- mem_we  out  1  write strobe; 1 only in MEM for stores.
- addr_sel  out  1  0 = PC, 1 = data address register.
- pc_inc  out  1  PC+1 pulse.
- pc_write  out  1  PC load pulse.
- pc_src  out  1  0 = immediate, 1 = register.
- rdata_load  out  1  datapath captures mem_rdata for a load.
- reg_write  out  1  register file write pulse.
- wb_sel  out  2  0 ALU, 1 memory, 2 link (PC), 3 immediate.
- instr_done  out  1  one-cycle pulse in WB.
- illegal  out  1  high while in TRAP.
- state  out  3  IDLE=0, F0=1, F1=2, DEC=3, EXEC=4, MEM=5, WB=6, TRAP=7.

## Operation
- IDLE: all strobes 0. Goes to F0 when run=1.
- F0: mem_req=1, addr_sel=0. On mem_ack: ir[15:8]<=mem_rdata, pc_inc=1, go to F1. Otherwise hold.
- F1: same as F0, but loads ir[7:0]; then go to DEC.
- DEC: opcode is valid and the ROM is combinational. Latch alu_flags into alu_ctrl and ctrl_flags into a flag register.
  - Opcode 0xA or 0xB goes to TRAP.
  - All other opcodes go to EXEC.
- EXEC: the datapath uses alu_ctrl/imm_sel.
  - pc_write=1 if pc_imm | pc_reg | (cond_pc & cond_true).
  - pc_src=pc_reg.
  - If mw|mr, go to MEM; else go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=mw. Hold until mem_ack. On ack, rdata_load=mr, then go to WB.
- WB: instr_done=1. reg_write=~mw.
  - wb_sel priority: link→2, mr→1, ld→3, else 0.
  - Next state is F0 if run=1, else IDLE.
- TRAP: illegal=1, all strobes 0. Only rst exits.
- run=0 mid-instruction: the current instruction completes; the stop takes effect only at WB.
- mem_ack while mem_req=0: ignored.
- A pending bus request is never withdrawn except by rst.

## Timing
- rst=1 at an edge: state=IDLE, ir=0, alu_ctrl=0, flag register=0.
- From the first edge with rst high, all strobes are 0, illegal=0 and state=0. This includes abort of an in-flight request: mem_req is 0 after that edge.
- Strobes are Moore outputs of state and latched registers, except the ack-qualified ones (pc_inc, ir load, rdata_load), which are high only in the ack cycle.
- Zero-wait bus (ack in the first request cycle) gives these minimum latencies:
  - ALU/jump instruction: 5 cycles.
  - Load/store: 6 cycles.
- Each bus wait cycle adds 1 cycle.
- opcode changes only at the edge ending F0.
- alu_ctrl changes only at the edge ending DEC or on reset.

## Test plan
- Reset mid-F0 with mem_req=1 and no ack, rst for 1 cycle → mem_req=0, state=0 next cycle; with run=1, F0 re-entered one cycle after rst drops.
- Zero-wait ADD: bus returns 0x01, 0x23, run=1 → alu_ctrl=0x00, reg_write and wb_sel=0 in cycle 5, instr_done in cycle 5, two pc_inc pulses, F0 again in cycle 6.
- LDB 0xE1 0x00, ack delayed 3 cycles on each access → addr_sel=1 in MEM, rdata_load on ack, wb_sel=1, total 6+9=15 cycles.
- STB 0xD0 0x00 → mem_we=1 only in MEM ack cycle window, reg_write=0 in WB.
- Branch 0x90 0x04:
  - cond_true=0 → pc_write=0.
  - cond_true=1 → pc_write=1, pc_src=0.
  - JLR 0x7x → pc_src=1, wb_sel=2.
- Opcode 0xA → illegal=1 from cycle after DEC, no further mem_req even with run=1, cleared only by rst. Also drop run during EXEC → instruction completes, state returns to IDLE after WB.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Memory bus between the sequencer (master) and the bus/memory side (slave).
// Handshake: the master raises mem_req and keeps it, together with mem_we and
// addr_sel, stable until the cycle in which the slave returns mem_ack. The
// transfer completes in that ack cycle (mem_rdata is valid only then). An ack
// seen while mem_req is low carries no meaning and is ignored.
interface cpu_sequencer_if;
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       mem_ack;
   logic [7:0] mem_rdata;

   modport master (
      output mem_req, mem_we, addr_sel,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, addr_sel,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetches a 16-bit instruction as two bus
// bytes, latches the decode ROM outputs, then strobes the datapath through
// execute, optional memory access and writeback. Undefined opcodes trap.
module cpu_sequencer (
   input  logic                    clk,
   input  logic                    rst,
   cpu_sequencer_if.master         bus,
   input  logic                    run,
   input  logic                    cond_true,
   input  logic [7:0]              alu_flags,
   input  logic [7:0]              ctrl_flags,
   output logic [3:0]              opcode,
   output logic [15:0]             ir,
   output logic [7:0]              alu_ctrl,
   output logic                    imm_sel,
   output logic                    pc_inc,
   output logic                    pc_write,
   output logic                    pc_src,
   output logic                    rdata_load,
   output logic                    reg_write,
   output logic [1:0]              wb_sel,
   output logic                    instr_done,
   output logic                    illegal,
   output logic [2:0]              state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F0   = 3'd1,
      S_F1   = 3'd2,
      S_DEC  = 3'd3,
      S_EXEC = 3'd4,
      S_MEM  = 3'd5,
      S_WB   = 3'd6,
      S_TRAP = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] flags_q;
   logic       req, we, asel;

   // Named views of the latched control flags (bit7..0).
   logic f_cond_pc, f_pc_imm, f_pc_reg, f_link, f_mw, f_mr, f_ld;
   assign f_cond_pc = flags_q[7];
   assign imm_sel   = flags_q[6];
   assign f_pc_imm  = flags_q[5];
   assign f_pc_reg  = flags_q[4];
   assign f_link    = flags_q[3];
   assign f_mw      = flags_q[2];
   assign f_mr      = flags_q[1];
   assign f_ld      = flags_q[0];

   assign opcode       = ir[15:12];
   assign state        = state_q;
   assign bus.mem_req  = req;
   assign bus.mem_we   = we;
   assign bus.addr_sel = asel;

   // State register; reset also aborts any in-flight bus request.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Instruction register: high byte on the F0 ack, low byte on the F1 ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         ir <= 16'h0000;
      end else if (state_q == S_F0 && bus.mem_ack) begin
         ir[15:8] <= bus.mem_rdata;
      end else if (state_q == S_F1 && bus.mem_ack) begin
         ir[7:0] <= bus.mem_rdata;
      end
   end

   // Capture the combinational decode ROM outputs while in DEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_ctrl <= 8'h00;
         flags_q  <= 8'h00;
      end else if (state_q == S_DEC) begin
         alu_ctrl <= alu_flags;
         flags_q  <= ctrl_flags;
      end
   end

   // Next-state and strobe decode; ack-qualified strobes fire only with mem_ack.
   always_comb begin
      state_d    = state_q;
      req        = 1'b0;
      we         = 1'b0;
      asel       = 1'b0;
      pc_inc     = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      rdata_load = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = 2'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_F0;
         end
         S_F0: begin
            req = 1'b1;
            if (bus.mem_ack) begin
               pc_inc  = 1'b1;
               state_d = S_F1;
            end
         end
         S_F1: begin
            req = 1'b1;
            if (bus.mem_ack) begin
               pc_inc  = 1'b1;
               state_d = S_DEC;
            end
         end
         S_DEC: begin
            if (ir[15:12] == 4'hA || ir[15:12] == 4'hB) state_d = S_TRAP;
            else                                        state_d = S_EXEC;
         end
         S_EXEC: begin
            pc_write = f_pc_imm | f_pc_reg | (f_cond_pc & cond_true);
            pc_src   = f_pc_reg;
            state_d  = (f_mw | f_mr) ? S_MEM : S_WB;
         end
         S_MEM: begin
            req  = 1'b1;
            asel = 1'b1;
            we   = f_mw;
            if (bus.mem_ack) begin
               rdata_load = f_mr;
               state_d    = S_WB;
            end
         end
         S_WB: begin
            instr_done = 1'b1;
            reg_write  = ~f_mw;
            if (f_link)    wb_sel = 2'd2;
            else if (f_mr) wb_sel = 2'd1;
            else if (f_ld) wb_sel = 2'd3;
            else           wb_sel = 2'd0;
            state_d = run ? S_F0 : S_IDLE;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a decode ROM model, a bus responder with per-access
// wait states, a driver issuing directed instructions, and a monitor that
// tallies per-instruction strobes and compares them at instr_done.
module tb_cpu_sequencer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        run = 1'b0;
   logic        cond_true = 1'b0;
   logic [7:0]  alu_flags, ctrl_flags;
   logic [3:0]  opcode;
   logic [15:0] ir;
   logic [7:0]  alu_ctrl;
   logic        imm_sel, pc_inc, pc_write, pc_src, rdata_load, reg_write;
   logic [1:0]  wb_sel;
   logic        instr_done, illegal;
   logic [2:0]  state;

   cpu_sequencer_if bif ();

   cpu_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bif),
      .run        (run),
      .cond_true  (cond_true),
      .alu_flags  (alu_flags),
      .ctrl_flags (ctrl_flags),
      .opcode     (opcode),
      .ir         (ir),
      .alu_ctrl   (alu_ctrl),
      .imm_sel    (imm_sel),
      .pc_inc     (pc_inc),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .rdata_load (rdata_load),
      .reg_write  (reg_write),
      .wb_sel     (wb_sel),
      .instr_done (instr_done),
      .illegal    (illegal),
      .state      (state)
   );

   // ---------------- decode ROM model ----------------
   always_comb begin
      alu_flags  = 8'h00;
      ctrl_flags = 8'h00;
      case (opcode)
         4'h1: alu_flags = 8'h5C;
         4'h3: ctrl_flags = 8'h41;                         // imm | ld
         4'h6: ctrl_flags = 8'h09;                         // link | ld
         4'h7: begin alu_flags = 8'h21; ctrl_flags = 8'h18; end // pc_reg | link
         4'h8: ctrl_flags = 8'h60;                         // imm | pc_imm
         4'h9: ctrl_flags = 8'hC0;                         // cond_pc | imm
         4'hA, 4'hB: begin alu_flags = 8'hFF; ctrl_flags = 8'hFF; end
         4'hD: begin alu_flags = 8'h82; ctrl_flags = 8'h04; end // mw
         4'hE: begin alu_flags = 8'h82; ctrl_flags = 8'h02; end // mr
         4'hF: ctrl_flags = 8'h03;                         // mr | ld
         default: ;
      endcase
   end

   // ---------------- bus responder ----------------
   typedef struct {
      logic [7:0] data;
      int         delay;
   } bus_t;
   bus_t bus_q[$];
   logic spurious_ack = 1'b0;

   initial begin
      int wait_cnt;
      wait_cnt = 0;
      bif.mem_ack   = 1'b0;
      bif.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (bif.mem_req === 1'b1) begin
            if (bus_q.size() > 0 && wait_cnt >= bus_q[0].delay) begin
               bif.mem_ack   = 1'b1;
               bif.mem_rdata = bus_q[0].data;
               void'(bus_q.pop_front());
               wait_cnt = 0;
            end else begin
               bif.mem_ack = 1'b0;
               if (bus_q.size() > 0) wait_cnt++;
            end
         end else begin
            bif.mem_ack   = spurious_ack;
            bif.mem_rdata = spurious_ack ? 8'hFF : 8'h00;
            wait_cnt      = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [15:0] ir;
      logic [7:0]  alu;
      logic [7:0]  cyc;
      logic [1:0]  inc;
      logic [1:0]  pcw;
      logic        src;
      logic [1:0]  rl;
      logic [3:0]  we;
      logic [3:0]  dat;
      logic        rw;
      logic [1:0]  wb;
      logic        imm;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk_exp(input logic [15:0] i, input logic [7:0] a,
                                   input int cyc, input int pcw, input logic src,
                                   input int rl, input int we, input int dat,
                                   input logic rw, input logic [1:0] wb,
                                   input logic imm);
      exp_t e;
      e.ir = i; e.alu = a; e.cyc = 8'(cyc); e.inc = 2'd2; e.pcw = 2'(pcw);
      e.src = src; e.rl = 2'(rl); e.we = 4'(we); e.dat = 4'(dat);
      e.rw = rw; e.wb = wb; e.imm = imm;
      return e;
   endfunction

   // Monitor: tallies strobes across one instruction, compares at instr_done.
   initial begin
      int cyc, inc, pcw, rl, we, dat;
      logic src;
      exp_t e;
      cyc = 0; inc = 0; pcw = 0; rl = 0; we = 0; dat = 0; src = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (state == 3'd0 || state == 3'd7 || state === 3'bx) begin
            cyc = 0; inc = 0; pcw = 0; rl = 0; we = 0; dat = 0; src = 1'b0;
         end else begin
            cyc++;
            if (pc_inc)     inc++;
            if (pc_write)   pcw++;
            if (rdata_load) rl++;
            if (bif.mem_we) we++;
            if (bif.mem_req && bif.addr_sel) dat++;
            if (state == 3'd4) src = pc_src;
            if (instr_done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("ir",         ir,        e.ir);
                  check("alu_ctrl",   alu_ctrl,  e.alu);
                  check("cycles",     cyc,       e.cyc);
                  check("pc_inc_cnt", inc,       e.inc);
                  check("pc_write",   pcw,       e.pcw);
                  check("pc_src",     src,       e.src);
                  check("rdata_load", rl,        e.rl);
                  check("mem_we_cnt", we,        e.we);
                  check("data_addr",  dat,       e.dat);
                  check("reg_write",  reg_write, e.rw);
                  check("wb_sel",     wb_sel,    e.wb);
                  check("imm_sel",    imm_sel,   e.imm);
               end
               cyc = 0; inc = 0; pcw = 0; rl = 0; we = 0; dat = 0; src = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic wait_state(input logic [2:0] s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (state == s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (instr_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      bus_q.delete();
   endtask

   // Issue one instruction; unless keep is set, run drops during EXEC.
   task automatic run_instr(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit mem_op,
                            input int delay, input logic cond, input bit keep,
                            input exp_t e);
      bit ok;
      exp_q.push_back(e);
      bus_q.push_back('{b0, delay});
      bus_q.push_back('{b1, delay});
      if (mem_op) bus_q.push_back('{b2, delay});
      cond_true = cond;
      run = 1'b1;
      if (!keep) begin
         wait_state(3'd4, ok);
         check("reach_exec", ok, 1);
         run = 1'b0;
      end
      wait_done(ok);
      check("reach_done", ok, 1);
      if (!ok) begin
         exp_q.delete();
         do_reset();
         return;
      end
      tick();
      check("post_wb_state", state, keep ? 3'd1 : 3'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit ok;
      do_reset();
      check("rst_state",    state,       3'd0);
      check("rst_ir",       ir,          16'h0000);
      check("rst_alu_ctrl", alu_ctrl,    8'h00);
      check("rst_mem_req",  bif.mem_req, 1'b0);
      check("rst_illegal",  illegal,     1'b0);
      check("rst_imm_sel",  imm_sel,     1'b0);

      // Ack while no request is pending must be ignored.
      spurious_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("spur_state",  state,  3'd0);
         check("spur_pc_inc", pc_inc, 1'b0);
      end
      spurious_ack = 1'b0;
      tick();
      check("spur_ir", ir, 16'h0000);

      // Zero-wait ADD with run held: F0 again in cycle 6, then stalls.
      run_instr(8'h01, 8'h23, 8'h00, 1'b0, 0, 1'b0, 1'b1,
                mk_exp(16'h0123, 8'h00, 5, 0, 1'b0, 0, 0, 0, 1'b1, 2'd0, 1'b0));
      check("f0_stall_req", bif.mem_req, 1'b1);
      // Reset in the middle of the unanswered fetch.
      rst = 1'b1;
      tick();
      check("abort_mem_req",  bif.mem_req, 1'b0);
      check("abort_state",    state,       3'd0);
      check("abort_ir",       ir,          16'h0000);
      check("abort_alu_ctrl", alu_ctrl,    8'h00);
      rst = 1'b0;
      tick();
      check("refetch_state", state, 3'd1);
      do_reset();
      check("idle_again", state, 3'd0);

      // ALU op with one wait state per fetch; cond_true without cond_pc.
      run_instr(8'h15, 8'hAA, 8'h00, 1'b0, 1, 1'b1, 1'b0,
                mk_exp(16'h15AA, 8'h5C, 7, 0, 1'b0, 0, 0, 0, 1'b1, 2'd0, 1'b0));
      // LDB, three wait cycles on every access: 6 + 9 cycles.
      run_instr(8'hE1, 8'h00, 8'h5A, 1'b1, 3, 1'b0, 1'b0,
                mk_exp(16'hE100, 8'h82, 15, 0, 1'b0, 1, 0, 4, 1'b1, 2'd1, 1'b0));
      // STB, zero wait.
      run_instr(8'hD0, 8'h00, 8'h33, 1'b1, 0, 1'b0, 1'b0,
                mk_exp(16'hD000, 8'h82, 6, 0, 1'b0, 0, 1, 1, 1'b0, 2'd0, 1'b0));
      // Conditional branch, not taken then taken.
      run_instr(8'h90, 8'h04, 8'h00, 1'b0, 0, 1'b0, 1'b0,
                mk_exp(16'h9004, 8'h00, 5, 0, 1'b0, 0, 0, 0, 1'b1, 2'd0, 1'b1));
      run_instr(8'h90, 8'h04, 8'h00, 1'b0, 0, 1'b1, 1'b0,
                mk_exp(16'h9004, 8'h00, 5, 1, 1'b0, 0, 0, 0, 1'b1, 2'd0, 1'b1));
      // JLR: register target, link writeback.
      run_instr(8'h71, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0,
                mk_exp(16'h7100, 8'h21, 5, 1, 1'b1, 0, 0, 0, 1'b1, 2'd2, 1'b0));
      // Load immediate, link beating ld, mr beating ld, immediate jump.
      run_instr(8'h32, 8'h07, 8'h00, 1'b0, 0, 1'b0, 1'b0,
                mk_exp(16'h3207, 8'h00, 5, 0, 1'b0, 0, 0, 0, 1'b1, 2'd3, 1'b1));
      run_instr(8'h60, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0,
                mk_exp(16'h6000, 8'h00, 5, 0, 1'b0, 0, 0, 0, 1'b1, 2'd2, 1'b0));
      run_instr(8'hF0, 8'h01, 8'h77, 1'b1, 0, 1'b0, 1'b0,
                mk_exp(16'hF001, 8'h00, 6, 0, 1'b0, 1, 0, 1, 1'b1, 2'd1, 1'b0));
      run_instr(8'h82, 8'h10, 8'h00, 1'b0, 0, 1'b1, 1'b0,
                mk_exp(16'h8210, 8'h00, 5, 1, 1'b0, 0, 0, 0, 1'b1, 2'd0, 1'b1));

      // Undefined opcode traps; run stays high, only reset leaves TRAP.
      bus_q.push_back('{8'hA0, 0});
      bus_q.push_back('{8'h00, 0});
      run = 1'b1;
      wait_state(3'd3, ok);
      check("trap_reach_dec", ok, 1);
      tick();
      check("trap_state",   state,   3'd7);
      check("trap_illegal", illegal, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("trap_no_req",    bif.mem_req, 1'b0);
         check("trap_held",      illegal,     1'b1);
         check("trap_no_pc_inc", pc_inc,      1'b0);
      end
      rst = 1'b1;
      tick();
      check("trap_exit_state",   state,   3'd0);
      check("trap_exit_illegal", illegal, 1'b0);
      rst = 1'b0;
      run = 1'b0;
      tick();
      check("trap_exit_idle", state, 3'd0);

      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog in case a bounded wait is somehow bypassed.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
